// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: Wishbone master that initialises i2c_master_top and runs
// single-register I2C write/read transactions, reporting a status per command.
module i2c_txn_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'h0063,
    parameter logic [19:0] POLL_LIMIT = 20'd1000000
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_status,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i
);
    typedef enum logic [3:0] {
        INIT_PRLO, INIT_PRHI, INIT_CTR, IDLE, TXR, CR, POLL, RXR, STOP, WAIT_IDLE, RESP
    } state_t;

    state_t      state, state_n;
    logic        stb, stb_n, ack, accept;
    logic [1:0]  step, step_n, st, st_n;
    logic [7:0]  rd, rd_n;
    logic [19:0] cnt, cnt_n;
    logic        rw;
    logic [6:0]  addr;
    logic [7:0]  rg, wdata;
    logic [2:0]  adr;
    logic [7:0]  dat;
    logic        we;

    assign ack       = stb & wb_ack_i;
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RESP;
    assign wb_stb_o  = stb;
    assign wb_cyc_o  = stb;
    assign wb_adr_o  = stb ? adr : 3'd0;
    assign wb_dat_o  = stb ? dat : 8'd0;
    assign wb_we_o   = stb & we;

    // step: 0 addr+W, 1 reg, 2 wdata (write) or addr+R (read), 3 read byte
    always_comb begin
        state_n = state;
        step_n  = step;
        st_n    = st;
        rd_n    = rd;
        cnt_n   = cnt;
        adr     = 3'd0;
        dat     = 8'd0;
        we      = 1'b0;
        stb_n   = state != IDLE && state != RESP && !ack;
        case (state)
            INIT_PRLO: begin
                dat = PRESCALE[7:0];
                we  = 1'b1;
                if (ack) state_n = INIT_PRHI;
            end
            INIT_PRHI: begin
                adr = 3'd1;
                dat = PRESCALE[15:8];
                we  = 1'b1;
                if (ack) state_n = INIT_CTR;
            end
            INIT_CTR: begin
                adr = 3'd2;
                dat = 8'h80;
                we  = 1'b1;
                if (ack) state_n = IDLE;
            end
            IDLE: begin
                if (cmd_valid) begin
                    state_n = TXR;
                    step_n  = 2'd0;
                    st_n    = 2'b00;
                end
            end
            TXR: begin
                adr = 3'd3;
                dat = step == 2'd0 ? {addr, 1'b0} : step == 2'd1 ? rg : rw ? {addr, 1'b1} : wdata;
                we  = 1'b1;
                if (ack) state_n = CR;
            end
            CR: begin
                adr = 3'd4;
                dat = step == 2'd0 ? 8'h90 : step == 2'd1 ? 8'h10 : step == 2'd2 ? (rw ? 8'h90 : 8'h50) : 8'h68;
                we  = 1'b1;
                if (ack) state_n = POLL;
            end
            POLL: begin
                adr = 3'd4;
                if (ack) begin
                    if (wb_dat_i[1]) begin
                        if (cnt + 20'd1 == POLL_LIMIT) begin
                            st_n    = 2'b11;
                            state_n = STOP;
                        end else cnt_n = cnt + 20'd1;
                    end else if (wb_dat_i[5]) begin
                        st_n    = 2'b10;
                        state_n = RESP;
                    end else if (wb_dat_i[7] && step != 2'd3) begin
                        st_n    = 2'b01;
                        state_n = (step == 2'd2 && !rw) ? WAIT_IDLE : STOP;
                    end else if (step == 2'd3) state_n = RXR;
                    else if (step == 2'd2 && !rw) state_n = WAIT_IDLE;
                    else begin
                        step_n  = step + 2'd1;
                        state_n = step == 2'd2 ? CR : TXR;
                    end
                end
            end
            RXR: begin
                adr = 3'd3;
                if (ack) begin
                    rd_n    = wb_dat_i;
                    state_n = WAIT_IDLE;
                end
            end
            STOP: begin
                adr = 3'd4;
                dat = 8'h40;
                we  = 1'b1;
                if (ack) state_n = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                adr = 3'd4;
                if (ack) begin
                    if (!wb_dat_i[6]) state_n = RESP;
                    else if (cnt + 20'd1 == POLL_LIMIT) begin
                        st_n    = 2'b11;
                        state_n = RESP;
                    end else cnt_n = cnt + 20'd1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = INIT_PRLO;
        endcase
        if (state_n != state) cnt_n = 20'd0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= INIT_PRLO;
            stb        <= 1'b0;
            step       <= 2'd0;
            st         <= 2'b00;
            rd         <= 8'd0;
            cnt        <= 20'd0;
            rw         <= 1'b0;
            addr       <= 7'd0;
            rg         <= 8'd0;
            wdata      <= 8'd0;
            rsp_status <= 2'b00;
            rsp_rdata  <= 8'd0;
        end else begin
            state <= state_n;
            stb   <= stb_n;
            step  <= step_n;
            st    <= st_n;
            rd    <= rd_n;
            cnt   <= cnt_n;
            if (accept) begin
                rw    <= cmd_rw;
                addr  <= cmd_addr;
                rg    <= cmd_reg;
                wdata <= cmd_wdata;
            end
            if (state_n == RESP) begin
                rsp_status <= st_n;
                if (rw && st_n == 2'b00) rsp_rdata <= rd_n;
            end
        end
    end
endmodule
